// File: rtl/fetch_unit_if.sv
// Instruction-memory request bus between the fetch stage and instruction memory.
// Latency: none, plain wires; one request outstanding, completed by IMemAck.
// Backpressure: requester holds IMemReq/IMemAddr stable until IMemAck.
interface fetch_unit_if;
   logic        IMemReq;
   logic [31:0] IMemAddr;
   logic        IMemAck;
   logic [31:0] IMemData;

   modport master (
      output IMemReq,
      output IMemAddr,
      input  IMemAck,
      input  IMemData
   );

   modport slave (
      input  IMemReq,
      input  IMemAddr,
      output IMemAck,
      output IMemData
   );
endinterface

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, one outstanding imem request, registered word to decode.
// Latency: IMemAck to FetchData_IF is one cycle; a zero-wait memory gives one word per cycle.
// Backpressure: AnyStall holds outputs, an ack under stall parks in a one-entry skid (HOLD).
// Optional feature macro: DELAY_SLOT_EN (jumps deliver the sequential delay-slot word first).
module fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         AnyStall,
   input  logic         flush,
   input  logic         BrTaken_EX,
   input  logic [31:0]  BrTgt_EX,
   input  logic         Jump_ID,
   input  logic [15:0]  JumpTgt_ID,
   fetch_unit_if.master imem,
   output logic [31:0]  FetchData_IF,
   output logic [31:0]  FetchPc_IF,
   output logic         FetchValid_IF
);
   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_HOLD = 2'd1,
      S_DROP = 2'd2
   } state_t;

   state_t      r_state, w_state_nxt;
   logic [31:0] r_pc, w_pc_nxt;
   logic [31:0] r_dat, w_dat_nxt;
   logic [31:0] r_fpc, w_fpc_nxt;
   logic        r_vld, w_vld_nxt;
   logic [31:0] r_skid_dat, w_skid_dat_nxt;
   logic [31:0] r_skid_pc, w_skid_pc_nxt;
   logic [31:0] r_drop_addr, w_drop_addr_nxt;
   logic        r_pend_vld, w_pend_vld_nxt;
   logic [31:0] r_pend_tgt, w_pend_tgt_nxt;

   logic        w_req, w_ack, w_jump, w_squash;
   logic [31:0] w_addr, w_seq_pc, w_fpc_inc, w_jump_tgt, w_br_tgt;

   // Request/address generation and redirect target arithmetic
   always_comb begin
      w_req      = (r_state != S_HOLD);
      w_addr     = (r_state == S_DROP) ? r_drop_addr : r_pc;
      w_ack      = w_req && imem.IMemAck;
      w_seq_pc   = r_pend_vld ? r_pend_tgt : (r_pc + 32'd4);
      w_fpc_inc  = r_fpc + 32'd4;
      // upper bits come from the delay-slot address so a carry out of bit 17 is honoured
      w_jump_tgt = (w_fpc_inc & 32'hFFFC_0000) | {14'd0, JumpTgt_ID, 2'b00};
      w_br_tgt   = BrTgt_EX & 32'hFFFF_FFFC;
      w_jump     = Jump_ID && !AnyStall && r_vld;
   end

`ifdef DELAY_SLOT_EN
   assign w_squash = flush;
`else
   assign w_squash = flush || w_jump;
`endif

   assign imem.IMemReq  = w_req;
   assign imem.IMemAddr = w_addr;

   assign FetchData_IF  = r_dat;
   assign FetchPc_IF    = r_fpc;
   assign FetchValid_IF = r_vld;

   // Next-state and datapath decisions; redirects take priority over sequential flow
   always_comb begin
      w_state_nxt     = r_state;
      w_pc_nxt        = r_pc;
      w_dat_nxt       = r_dat;
      w_fpc_nxt       = r_fpc;
      w_vld_nxt       = r_vld;
      w_skid_dat_nxt  = r_skid_dat;
      w_skid_pc_nxt   = r_skid_pc;
      w_drop_addr_nxt = r_drop_addr;
      w_pend_vld_nxt  = r_pend_vld;
      w_pend_tgt_nxt  = r_pend_tgt;

      if (w_squash) begin
         // bubble out; any word acked now is stale, leaving HOLD empties the skid
         w_dat_nxt      = NOP_INSTR;
         w_vld_nxt      = 1'b0;
         w_pend_vld_nxt = 1'b0;
         if (flush) begin
            if (BrTaken_EX) begin
               w_pc_nxt = w_br_tgt;
            end
         end else begin
            w_pc_nxt = w_jump_tgt;
         end
         if (w_req && !w_ack) begin
            w_state_nxt     = S_DROP;
            w_drop_addr_nxt = w_addr;
         end else begin
            w_state_nxt = S_REQ;
         end
      end else begin
         case (r_state)
            S_REQ: begin
               if (w_ack) begin
                  if (AnyStall) begin
                     w_skid_dat_nxt = imem.IMemData;
                     w_skid_pc_nxt  = r_pc;
                     w_state_nxt    = S_HOLD;
                  end else begin
                     w_dat_nxt = imem.IMemData;
                     w_fpc_nxt = r_pc;
                     w_vld_nxt = 1'b1;
                  end
                  w_pc_nxt       = w_seq_pc;
                  w_pend_vld_nxt = 1'b0;
               end else if (!AnyStall) begin
                  w_dat_nxt = NOP_INSTR;
                  w_vld_nxt = 1'b0;
               end
            end
            S_HOLD: begin
               if (!AnyStall) begin
                  w_dat_nxt   = r_skid_dat;
                  w_fpc_nxt   = r_skid_pc;
                  w_vld_nxt   = 1'b1;
                  w_state_nxt = S_REQ;
               end
            end
            S_DROP: begin
               if (w_ack) begin
                  w_state_nxt = S_REQ;
               end
            end
            default: begin
               w_state_nxt = S_REQ;
            end
         endcase
`ifdef DELAY_SLOT_EN
         // the delay slot is the word at jump PC+4: either already taken (skid or this ack)
         // so the PC can jump now, or still to come, so park the target until it is accepted
         if (w_jump) begin
            if ((r_state == S_HOLD) || ((r_state == S_REQ) && w_ack)) begin
               w_pc_nxt       = w_jump_tgt;
               w_pend_vld_nxt = 1'b0;
            end else begin
               w_pend_vld_nxt = 1'b1;
               w_pend_tgt_nxt = w_jump_tgt;
            end
         end
`endif
      end
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= S_REQ;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // PC, output, skid, drop-address and pending-jump registers
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_pc        <= RESET_PC;
         r_dat       <= NOP_INSTR;
         r_fpc       <= 32'd0;
         r_vld       <= 1'b0;
         r_skid_dat  <= 32'd0;
         r_skid_pc   <= 32'd0;
         r_drop_addr <= 32'd0;
         r_pend_vld  <= 1'b0;
         r_pend_tgt  <= 32'd0;
      end else begin
         r_pc        <= w_pc_nxt;
         r_dat       <= w_dat_nxt;
         r_fpc       <= w_fpc_nxt;
         r_vld       <= w_vld_nxt;
         r_skid_dat  <= w_skid_dat_nxt;
         r_skid_pc   <= w_skid_pc_nxt;
         r_drop_addr <= w_drop_addr_nxt;
         r_pend_vld  <= w_pend_vld_nxt;
         r_pend_tgt  <= w_pend_tgt_nxt;
      end
   end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: instruction memory returns addr>>2 after a programmable latency.
// A program-order model tracks the next PC decode must see; directed scenarios pin literals.
module tb_fetch_unit;
   localparam logic [31:0] NOP = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset, AnyStall, flush, BrTaken_EX, Jump_ID;
   logic [31:0] BrTgt_EX;
   logic [15:0] JumpTgt_ID;
   logic [31:0] FetchData_IF, FetchPc_IF;
   logic        FetchValid_IF;

   always #5 clk = ~clk;

   fetch_unit_if imem ();

   fetch_unit #(.RESET_PC(32'h0), .NOP_INSTR(NOP)) dut (
      .clk(clk), .reset(reset), .AnyStall(AnyStall), .flush(flush),
      .BrTaken_EX(BrTaken_EX), .BrTgt_EX(BrTgt_EX), .Jump_ID(Jump_ID),
      .JumpTgt_ID(JumpTgt_ID), .imem(imem), .FetchData_IF(FetchData_IF),
      .FetchPc_IF(FetchPc_IF), .FetchValid_IF(FetchValid_IF)
   );

   // memory: a request is acked in its mem_lat-th cycle (1 = same cycle)
   int mem_lat;
   int wait_cnt;
   assign imem.IMemAck  = imem.IMemReq && ((wait_cnt + 1) >= mem_lat);
   assign imem.IMemData = imem.IMemAddr >> 2;
   always @(posedge clk) begin
      if (!reset) wait_cnt <= 0;
      else if (imem.IMemReq && imem.IMemAck) wait_cnt <= 0;
      else if (imem.IMemReq) wait_cnt <= wait_cnt + 1;
   end

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b, want %b", name, act, exp);
      end
   endtask

   // program-order model state
   logic [31:0] m_exp, m_last, m_pend_tgt, m_slot, ovr_pc, jt;
   logic        m_pend_vld, ovr_pending;
   logic [31:0] p_dat, p_pc, p_addr;
   logic        p_vld, p_stall, p_flush, p_req, p_ack;

   // per-cycle compare against the model, then apply the events of the coming edge
   task automatic compare_cycle();
      if (reset !== 1'b1) begin
         m_exp = 32'h0; m_last = 32'h0; m_pend_vld = 1'b0;
         p_stall = 1'b0; p_flush = 1'b0; p_req = 1'b0; p_ack = 1'b0;
         return;
      end
      if (ovr_pending) begin
         m_exp = ovr_pc;
         ovr_pending = 1'b0;
      end
      if (p_flush) begin
         chk1("flush_bubble_vld", FetchValid_IF, 1'b0);
         chk("flush_bubble_dat", FetchData_IF, NOP);
      end else if (p_stall) begin
         chk1("stall_hold_vld", FetchValid_IF, p_vld);
         chk("stall_hold_pc", FetchPc_IF, p_pc);
         chk("stall_hold_dat", FetchData_IF, p_dat);
      end else if (FetchValid_IF) begin
         chk("order_pc", FetchPc_IF, m_exp);
         chk("order_dat", FetchData_IF, m_exp >> 2);
         m_last = m_exp;
         if (m_pend_vld && (m_exp == m_slot)) begin
            m_exp = m_pend_tgt;
            m_pend_vld = 1'b0;
         end else begin
            m_exp = m_exp + 32'd4;
         end
      end else begin
         chk("bubble_dat", FetchData_IF, NOP);
      end
      if (p_req && !p_ack) begin
         chk1("req_held", imem.IMemReq, 1'b1);
         chk("addr_stable", imem.IMemAddr, p_addr);
      end
      if (flush) begin
         m_pend_vld = 1'b0;
         if (BrTaken_EX) m_exp = {BrTgt_EX[31:2], 2'b00};
      end else if (Jump_ID && !AnyStall && FetchValid_IF) begin
         jt = m_last + 32'd4;
         jt = {jt[31:18], JumpTgt_ID, 2'b00};
`ifdef DELAY_SLOT_EN
         m_pend_vld = 1'b1;
         m_pend_tgt = jt;
         m_slot     = m_last + 32'd4;
`else
         m_exp = jt;
`endif
      end
      p_stall = AnyStall; p_flush = flush;
      p_dat = FetchData_IF; p_pc = FetchPc_IF; p_vld = FetchValid_IF;
      p_req = imem.IMemReq; p_ack = imem.IMemAck; p_addr = imem.IMemAddr;
   endtask

   task automatic tick();
      @(negedge clk);
      compare_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      reset = 1'b0; AnyStall = 1'b0; flush = 1'b0; BrTaken_EX = 1'b0;
      BrTgt_EX = 32'h0; Jump_ID = 1'b0; JumpTgt_ID = 16'h0;
      repeat (3) tick();
      chk1("rst_vld", FetchValid_IF, 1'b0);
      chk("rst_pc", FetchPc_IF, 32'h0);
      chk("rst_dat", FetchData_IF, NOP);
      reset = 1'b1;
      chk1("rst_first_req", imem.IMemReq, 1'b1);
      chk("rst_first_addr", imem.IMemAddr, 32'h0);
   endtask

   task automatic wait_valid(input string name, input logic [31:0] exp_pc);
      logic got;
      got = 1'b0;
      for (int i = 0; i < 30 && !got; i++) begin
         tick();
         if (FetchValid_IF) got = 1'b1;
      end
      chk1({name, "_seen"}, got, 1'b1);
      chk({name, "_pc"}, FetchPc_IF, exp_pc);
   endtask

   initial begin
      ovr_pending = 1'b0;
      ovr_pc = 32'h0;

      // A: zero-wait memory, one word per cycle
      mem_lat = 1;
      apply_reset();
      for (int k = 0; k < 4; k++) begin
         tick();
         chk1("a_vld", FetchValid_IF, 1'b1);
         chk("a_pc", FetchPc_IF, 32'(k * 4));
      end

      // B: three-cycle memory, three bubbles before PC 0
      mem_lat = 3;
      apply_reset();
      for (int k = 0; k < 3; k++) begin
         chk("b_addr_wait", imem.IMemAddr, 32'h0);
         chk1("b_bubble", FetchValid_IF, 1'b0);
         tick();
      end
      chk1("b_first_vld", FetchValid_IF, 1'b1);
      chk("b_first_pc", FetchPc_IF, 32'h0);

      // C: four stall cycles while the ack for PC 8 arrives
      mem_lat = 1;
      apply_reset();
      tick(); tick();
      chk("c_pre_pc", FetchPc_IF, 32'h4);
      AnyStall = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("c_hold_pc", FetchPc_IF, 32'h4);
         chk1("c_hold_noreq", imem.IMemReq, 1'b0);
         if (k == 3) AnyStall = 1'b0;
      end
      tick();
      chk("c_skid_pc", FetchPc_IF, 32'h8);
      chk("c_next_addr", imem.IMemAddr, 32'hC);
      tick();
      chk("c_after_pc", FetchPc_IF, 32'hC);

      // D: taken branch while the request to 0x10 waits; misaligned target masked
      apply_reset();
      repeat (4) tick();
      mem_lat = 3;
      chk("d_out_addr", imem.IMemAddr, 32'h10);
      flush = 1'b1; BrTaken_EX = 1'b1; BrTgt_EX = 32'h0000_0103;
      tick();
      flush = 1'b0; BrTaken_EX = 1'b0;
      chk("d_drop_addr", imem.IMemAddr, 32'h10);
      wait_valid("d_first", 32'h100);

      // E: jump at PC 0x20 with target index 0x0040
      mem_lat = 1;
      apply_reset();
      repeat (9) tick();
      chk("e_jump_pc", FetchPc_IF, 32'h20);
      Jump_ID = 1'b1; JumpTgt_ID = 16'h0040;
      tick();
      Jump_ID = 1'b0;
`ifdef DELAY_SLOT_EN
      chk("e_slot_pc", FetchPc_IF, 32'h24);
      tick();
      chk("e_tgt_pc", FetchPc_IF, 32'h100);
`else
      chk1("e_bubble", FetchValid_IF, 1'b0);
      tick();
      chk("e_tgt_pc", FetchPc_IF, 32'h100);
`endif

      // F: branch to the top word; sequential fetch wraps to 0
      flush = 1'b1; BrTaken_EX = 1'b1; BrTgt_EX = 32'hFFFF_FFFE;
      tick();
      flush = 1'b0; BrTaken_EX = 1'b0;
      chk1("f_bubble", FetchValid_IF, 1'b0);
      tick();
      chk("f_top_pc", FetchPc_IF, 32'hFFFF_FFFC);
      tick();
      chk("f_wrap_pc", FetchPc_IF, 32'h0);

      // G: flush while stalled with PC 8 parked in the skid; refetch from the PC (0xC)
      apply_reset();
      tick(); tick();
      AnyStall = 1'b1;
      tick();
      flush = 1'b1;
      ovr_pc = 32'hC; ovr_pending = 1'b1;
      tick();
      flush = 1'b0; AnyStall = 1'b0;
      chk1("g_bubble", FetchValid_IF, 1'b0);
      chk("g_refetch_addr", imem.IMemAddr, 32'hC);
      wait_valid("g_refetch", 32'hC);
      repeat (3) tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
